// File: rtl/square_position_ctrl_pkg.sv
// Shared types and helpers for the moving-square position controller:
// direction codes, grid defaults and the per-axis cell stepping rule.
package square_position_ctrl_pkg;

    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_DEC  = 2'b01,
        DIR_INC  = 2'b10
    } dir_e;

    localparam int GRID_MAX_DEF = 6;
    localparam int INIT_X_DEF   = 3;
    localparam int INIT_Y_DEF   = 4;
    localparam int POS_W        = 3;

    typedef logic [POS_W-1:0] pos_t;

    // Edges are handled explicitly so a 3-bit grid never relies on natural overflow.
    function automatic pos_t step_cell(input pos_t cur, input dir_e dir,
                                       input pos_t grid_max, input logic wrap);
        pos_t nxt;
        nxt = cur;
        case (dir)
            DIR_DEC: begin
                if (cur == '0) nxt = wrap ? grid_max : '0;
                else           nxt = cur - pos_t'(1);
            end
            DIR_INC: begin
                if (cur >= grid_max) nxt = wrap ? '0 : grid_max;
                else                 nxt = cur + pos_t'(1);
            end
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    // Opposite presses in the same cycle cancel and keep the base value.
    function automatic dir_e resolve_dir(input dir_e base, input logic dec, input logic inc);
        dir_e r;
        r = base;
        if (dec && !inc)      r = DIR_DEC;
        else if (inc && !dec) r = DIR_INC;
        return r;
    endfunction

endpackage

// File: rtl/square_position_ctrl_if.sv
// Button/tick inputs and committed-position outputs of the position controller.
interface square_position_ctrl_if;
    import square_position_ctrl_pkg::*;

    logic btn_north;
    logic btn_south;
    logic btn_west;
    logic btn_east;
    logic frame_tick;
    pos_t pos_x;
    pos_t pos_y;
    logic moved;

    modport master (
        output btn_north, btn_south, btn_west, btn_east, frame_tick,
        input  pos_x, pos_y, moved
    );

    modport slave (
        input  btn_north, btn_south, btn_west, btn_east, frame_tick,
        output pos_x, pos_y, moved
    );
endinterface

// File: rtl/square_position_ctrl_btn_debounce.sv
// Two-flop synchroniser plus counting debouncer for one raw push-button;
// emits a registered one-cycle pulse when the debounced level rises.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic btn_raw,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;

    always_comb begin
        sync_d  = {sync_q[0], btn_raw};
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
                press_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/square_position_ctrl.sv
// Debounces the four direction buttons, collects one pending move per axis
// and commits it to the square's grid position on each frame tick.
module square_position_ctrl
    import square_position_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int GRID_MAX        = GRID_MAX_DEF,
    parameter int INIT_X          = INIT_X_DEF,
    parameter int INIT_Y          = INIT_Y_DEF,
    parameter bit WRAP            = 1'b0
) (
    input  logic Clock,
    input  logic Reset,
    square_position_ctrl_if.slave bus
);

    localparam pos_t GRID_L   = pos_t'(GRID_MAX);
    localparam pos_t INIT_X_L = pos_t'(INIT_X);
    localparam pos_t INIT_Y_L = pos_t'(INIT_Y);

    logic press_north;
    logic press_south;
    logic press_west;
    logic press_east;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_north (
        .Clock(Clock), .Reset(Reset), .btn_raw(bus.btn_north), .press(press_north)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_south (
        .Clock(Clock), .Reset(Reset), .btn_raw(bus.btn_south), .press(press_south)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_west (
        .Clock(Clock), .Reset(Reset), .btn_raw(bus.btn_west), .press(press_west)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_east (
        .Clock(Clock), .Reset(Reset), .btn_raw(bus.btn_east), .press(press_east)
    );

    pos_t pos_x_q, pos_x_d;
    pos_t pos_y_q, pos_y_d;
    dir_e pend_dx_q, pend_dx_d;
    dir_e pend_dy_q, pend_dy_d;
    logic moved_q, moved_d;

    // The tick commits the moves held before the edge; a press landing on the
    // same edge starts the next frame's pending move instead of being dropped.
    always_comb begin
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        moved_d   = 1'b0;
        pend_dx_d = resolve_dir(bus.frame_tick ? DIR_NONE : pend_dx_q, press_west, press_east);
        pend_dy_d = resolve_dir(bus.frame_tick ? DIR_NONE : pend_dy_q, press_north, press_south);
        if (bus.frame_tick) begin
            pos_x_d = step_cell(pos_x_q, pend_dx_q, GRID_L, WRAP);
            pos_y_d = step_cell(pos_y_q, pend_dy_q, GRID_L, WRAP);
            moved_d = (pos_x_d != pos_x_q) || (pos_y_d != pos_y_q);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pos_x_q   <= INIT_X_L;
            pos_y_q   <= INIT_Y_L;
            pend_dx_q <= DIR_NONE;
            pend_dy_q <= DIR_NONE;
            moved_q   <= 1'b0;
        end else begin
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            pend_dx_q <= pend_dx_d;
            pend_dy_q <= pend_dy_d;
            moved_q   <= moved_d;
        end
    end

    assign bus.pos_x = pos_x_q;
    assign bus.pos_y = pos_y_q;
    assign bus.moved = moved_q;

endmodule

// File: tb/tb_square_position_ctrl.sv
// Self-checking bench: a saturating and a wrapping controller share one button
// stream and are compared every cycle against a window-based behavioural model.
module tb_square_position_ctrl;

    localparam int D    = 4;
    localparam int GRID = 6;

    localparam logic [4:0] IDLE = 5'b00000;
    localparam logic [4:0] N    = 5'b00001;
    localparam logic [4:0] S    = 5'b00010;
    localparam logic [4:0] W    = 5'b00100;
    localparam logic [4:0] E    = 5'b01000;
    localparam logic [4:0] T    = 5'b10000;

    logic Clock;
    logic Reset;

    square_position_ctrl_if bus0 ();
    square_position_ctrl_if bus1 ();

    assign bus1.btn_north  = bus0.btn_north;
    assign bus1.btn_south  = bus0.btn_south;
    assign bus1.btn_west   = bus0.btn_west;
    assign bus1.btn_east   = bus0.btn_east;
    assign bus1.frame_tick = bus0.frame_tick;

    square_position_ctrl #(.DEBOUNCE_CYCLES(D), .WRAP(1'b0)) dut_sat (
        .Clock(Clock), .Reset(Reset), .bus(bus0)
    );
    square_position_ctrl #(.DEBOUNCE_CYCLES(D), .WRAP(1'b1)) dut_wrap (
        .Clock(Clock), .Reset(Reset), .bus(bus1)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    int errors;
    int checks;

    // Model: a button's debounced level flips once its last D synchronised
    // samples (taken 2..D+1 edges ago) all disagree with the current level.
    logic [D+1:0] m_hist [4];
    logic [3:0]   m_lvl;
    logic [3:0]   m_press;
    int           m_dx, m_dy;
    int           m_x [2];
    int           m_y [2];
    int           m_moved [2];
    logic [3:0]   raw_btn;

    assign raw_btn = {bus0.btn_east, bus0.btn_west, bus0.btn_south, bus0.btn_north};

    function automatic int move_cell(input int p, input int d, input bit wrap);
        int n;
        n = p + d;
        if (n < 0)    return wrap ? GRID : 0;
        if (n > GRID) return wrap ? 0 : GRID;
        return n;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 4; b++) m_hist[b] = '0;
        m_lvl   = '0;
        m_press = '0;
        m_dx    = 0;
        m_dy    = 0;
        for (int d = 0; d < 2; d++) begin
            m_x[d]     = 3;
            m_y[d]     = 4;
            m_moved[d] = 0;
        end
    endtask

    task automatic model_step(input logic tick);
        logic [D+1:0] h;
        logic [D-1:0] win;
        logic         flip;
        logic [3:0]   press_now;
        int           ndx, ndy, nx, ny;
        for (int b = 0; b < 4; b++) begin
            h            = {m_hist[b][D:0], raw_btn[b]};
            win          = h[D+1:2];
            flip         = (win == {D{~m_lvl[b]}});
            press_now[b] = flip & ~m_lvl[b];
            m_lvl[b]     = m_lvl[b] ^ flip;
            m_hist[b]    = h;
        end
        ndx = tick ? 0 : m_dx;
        ndy = tick ? 0 : m_dy;
        if (m_press[2] && !m_press[3]) ndx = -1;
        else if (m_press[3] && !m_press[2]) ndx = 1;
        if (m_press[0] && !m_press[1]) ndy = -1;
        else if (m_press[1] && !m_press[0]) ndy = 1;
        for (int d = 0; d < 2; d++) begin
            if (tick) begin
                nx         = move_cell(m_x[d], m_dx, d == 1);
                ny         = move_cell(m_y[d], m_dy, d == 1);
                m_moved[d] = ((nx != m_x[d]) || (ny != m_y[d])) ? 1 : 0;
                m_x[d]     = nx;
                m_y[d]     = ny;
            end else begin
                m_moved[d] = 0;
            end
        end
        m_dx    = ndx;
        m_dy    = ndy;
        m_press = press_now;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge Clock or posedge Reset);
            if (Reset) model_reset();
            else       model_step(bus0.frame_tick);
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d required=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Hand-computed expectations posted by the stimulus and checked at the next negedge.
    string pin_name;
    int    pin_x [2];
    int    pin_y [2];
    int    pin_m [2];
    int    pin_seq;

    initial begin
        int pin_seen;
        pin_seen = 0;
        forever begin
            @(negedge Clock);
            checkOutput("sat.pos_x",  int'(bus0.pos_x), m_x[0]);
            checkOutput("sat.pos_y",  int'(bus0.pos_y), m_y[0]);
            checkOutput("sat.moved",  int'(bus0.moved), m_moved[0]);
            checkOutput("wrap.pos_x", int'(bus1.pos_x), m_x[1]);
            checkOutput("wrap.pos_y", int'(bus1.pos_y), m_y[1]);
            checkOutput("wrap.moved", int'(bus1.moved), m_moved[1]);
            if (pin_seq != pin_seen) begin
                pin_seen = pin_seq;
                checkOutput({pin_name, ".sat.pos_x"},  int'(bus0.pos_x), pin_x[0]);
                checkOutput({pin_name, ".sat.pos_y"},  int'(bus0.pos_y), pin_y[0]);
                checkOutput({pin_name, ".sat.moved"},  int'(bus0.moved), pin_m[0]);
                checkOutput({pin_name, ".wrap.pos_x"}, int'(bus1.pos_x), pin_x[1]);
                checkOutput({pin_name, ".wrap.pos_y"}, int'(bus1.pos_y), pin_y[1]);
                checkOutput({pin_name, ".wrap.moved"}, int'(bus1.moved), pin_m[1]);
                checkOutput({pin_name, ".model.sat_y"}, m_y[0], pin_y[0]);
                checkOutput({pin_name, ".model.wrap_x"}, m_x[1], pin_x[1]);
            end
        end
    end

    task automatic expectState(input string name, input int x0, input int y0, input int mv0,
                               input int x1, input int y1, input int mv1);
        pin_name = name;
        pin_x[0] = x0;
        pin_y[0] = y0;
        pin_m[0] = mv0;
        pin_x[1] = x1;
        pin_y[1] = y1;
        pin_m[1] = mv1;
        pin_seq++;
    endtask

    // Each cycle: drive just after the rising edge so the next edge samples v.
    task automatic applyStimulus(input logic [4:0] v, input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
            bus0.btn_north  = v[0];
            bus0.btn_south  = v[1];
            bus0.btn_west   = v[2];
            bus0.btn_east   = v[3];
            bus0.frame_tick = v[4];
        end
    endtask

    task automatic pressBtn(input logic [4:0] v);
        applyStimulus(v, D + 4);
        applyStimulus(IDLE, D + 4);
    endtask

    task automatic frameTick();
        applyStimulus(T, 1);
        applyStimulus(IDLE, 1);
    endtask

    initial begin
        int exp_c0 [4];
        int exp_c1 [4];
        int exp_m0 [4];
        errors  = 0;
        checks  = 0;
        pin_seq = 0;
        exp_c0  = '{2, 1, 0, 0};
        exp_c1  = '{2, 1, 0, 6};
        exp_m0  = '{1, 1, 1, 0};

        Reset           = 1'b1;
        bus0.btn_north  = 1'b0;
        bus0.btn_south  = 1'b0;
        bus0.btn_west   = 1'b0;
        bus0.btn_east   = 1'b0;
        bus0.frame_tick = 1'b0;
        repeat (3) @(posedge Clock);
        #1 Reset = 1'b0;
        applyStimulus(IDLE, 2);
        expectState("reset", 3, 4, 0, 3, 4, 0);

        applyStimulus(N, 10);
        applyStimulus(IDLE, 2);
        frameTick();
        expectState("north", 3, 3, 1, 3, 3, 1);
        applyStimulus(IDLE, 1);
        expectState("north_pulse_end", 3, 3, 0, 3, 3, 0);
        applyStimulus(IDLE, 8);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(E, 2);
            applyStimulus(IDLE, 2);
        end
        applyStimulus(IDLE, 8);
        frameTick();
        expectState("bounce", 3, 3, 0, 3, 3, 0);

        for (int i = 0; i < 4; i++) begin
            pressBtn(W);
            frameTick();
            expectState($sformatf("west%0d", i), exp_c0[i], 3, exp_m0[i], exp_c1[i], 3, 1);
        end

        pressBtn(E);
        frameTick();
        expectState("east_wrap", 1, 3, 1, 0, 3, 1);

        for (int i = 0; i < 4; i++) begin
            pressBtn(N);
            frameTick();
            expectState($sformatf("north%0d", i), 1, exp_c0[i], exp_m0[i], 0, exp_c1[i], 1);
        end

        pressBtn(N | S);
        frameTick();
        expectState("north_south", 1, 0, 0, 0, 6, 0);

        applyStimulus(S, D + 2);
        applyStimulus(S | T, 1);
        applyStimulus(S, 1);
        expectState("south_on_tick", 1, 0, 0, 0, 6, 0);
        applyStimulus(IDLE, D + 4);
        frameTick();
        expectState("south_next_tick", 1, 1, 1, 0, 0, 1);

        applyStimulus(E, D);
        @(posedge Clock);
        #1;
        Reset         = 1'b1;
        bus0.btn_east = 1'b0;
        #2 Reset = 1'b0;
        expectState("async_reset", 3, 4, 0, 3, 4, 0);
        applyStimulus(IDLE, 10);
        frameTick();
        expectState("reset_mid_debounce", 3, 4, 0, 3, 4, 0);

        for (int seg = 0; seg < 250; seg++) begin
            logic [4:0] v;
            int         len;
            v[3:0] = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) v[3:0] = 4'b0000;
            len = $urandom_range(1, 12);
            for (int c = 0; c < len; c++) begin
                v[4] = ($urandom_range(0, 7) == 0);
                applyStimulus(v, 1);
            end
        end
        applyStimulus(IDLE, 12);
        frameTick();
        applyStimulus(IDLE, 2);

        @(negedge Clock);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/square_position_ctrl.md
Name: square_position_ctrl

Overview:
Upstream stage of the moving-square renderer. Synchronises and debounces the four raw push-buttons, converts each press into a single move request, and maintains the square's registered grid position (pos_x, pos_y) on a 7x7 grid. Moves are committed only on a frame tick from the sync generator, so the square never tears mid-frame. The renderer consumes pos_x/pos_y directly and no longer uses buttons as clocks.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable Clock cycles required to accept a level change (20 ms at 50 MHz)
GRID_MAX, 6, highest legal cell index on each axis (grid is 0..GRID_MAX)
INIT_X, 3, pos_x reset value
INIT_Y, 4, pos_y reset value
WRAP, 0, 0 = saturate at edges, 1 = wrap 0<->GRID_MAX

Ports:
Clock  in  1  system clock, 50 MHz
Reset  in  1  asynchronous, active-high
btn_north  in  1  raw button, asynchronous, bouncy; north = y-1
btn_south  in  1  raw button; south = y+1
btn_west  in  1  raw button; west = x-1
btn_east  in  1  raw button; east = x+1
frame_tick  in  1  one-cycle pulse per frame (start of vertical blanking), Clock domain
pos_x  out  3  committed column cell, 0..GRID_MAX
pos_y  out  3  committed row cell, 0..GRID_MAX
moved  out  1  one-cycle pulse, high in the cycle after pos_x or pos_y changed value

Behaviour:
- Reset: asynchronous, active-high; clock Clock. Reset dominates every other input.
- Reset values: pos_x=INIT_X, pos_y=INIT_Y, moved=0. All synchroniser flops, debounced levels, debounce counters and pending moves are cleared to 0.
- Per button, synchroniser: 2 flops.
- Per button, debouncer:
  - Counter clears whenever the synchronised value equals the debounced level.
  - Otherwise the counter increments. On reaching DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
- Press pulse: one cycle when the debounced level goes 0->1.
- Press latency: press pulse is high exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples the raw input high, provided the input is held steady. Releases generate no pulse.
- Pending move, per axis: pend_dx and pend_dy, each in {-1,0,+1}, stored as 2-bit codes.
  - A press pulse sets that axis's pending value.
  - Last press wins within a frame.
  - Opposite presses on the same axis in the same cycle leave that axis's pending value unchanged.
- Commit on frame_tick:
  - pos is updated from the pending values held before that edge, then pending is cleared.
  - A press pulse coincident with frame_tick becomes the new pending value for the next frame; it is not lost.
- Boundaries:
  - WRAP=0: x-1 at 0 stays 0; x+1 at GRID_MAX stays GRID_MAX. y axis identical.
  - WRAP=1: 0-1 -> GRID_MAX and GRID_MAX+1 -> 0. Wrap is explicit; natural 3-bit overflow must not be used.
- moved: registered; high for exactly one cycle after a commit that changed either coordinate. A commit blocked by saturation, or with no pending move, gives moved=0.
- Both axes commit on the same tick; a diagonal move produces one moved pulse.
- No combinational path from any input to any output.

Decomposition:
- Shared package: direction codes (DIR_NONE=2'b00, DIR_DEC=2'b01, DIR_INC=2'b10), GRID_MAX default, INIT_X/INIT_Y defaults.
- Sub-module btn_debounce holds the 2-flop synchroniser, counter, debounced level and press pulse. It is instantiated 4x; its parameter is DEBOUNCE_CYCLES.
- Pending and commit logic stays in the top level.

Test Plan (DEBOUNCE_CYCLES=4, defaults otherwise):
- Reset asserted, then released -> pos_x=3, pos_y=4, moved=0. Assert Reset mid-operation -> same values immediately, asynchronously.
- btn_north held high 10 cycles, then frame_tick -> press pulse at edge 6; after tick pos_y=3, pos_x=3, moved high exactly 1 cycle.
- btn_east toggles every 2 cycles for 20 cycles, then low, then frame_tick -> no press pulse; pos_x=3; moved=0.
- Four clean west presses, each followed by frame_tick, from pos_x=3 -> pos_x 2,1,0,0; moved pulses exactly 3 times.
- WRAP=1: with pos_x=6, east press then tick -> pos_x=0. With pos_y=0, north press then tick -> pos_y=6.
- Simultaneous cases:
  - north+south pressed in the same cycle, then tick -> pos_y unchanged, moved=0.
  - south press pulse on the same cycle as frame_tick -> unchanged at that tick, pos_y+1 at the next tick.
  - Reset pulsed at debounce count 2 -> no press pulse.
